// File: rtl/bcd_seg_mux_if.sv
// Digit-in / segment-out bundle between the BCD counter, the display mux and the LED driver.
interface bcd_seg_mux_if;
    logic       enable;
    logic [3:0] digit_1;
    logic [3:0] digit_2;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame_tick;

    modport master (output enable, digit_1, digit_2, input seg, an, frame_tick);
    modport slave  (input enable, digit_1, digit_2, output seg, an, frame_tick);
endinterface

// File: rtl/bcd_seg_mux.sv
// Two-digit time-multiplexed 7-segment driver with blank gaps and per-frame digit snapshot.
// Optional macro LEADING_ZERO_BLANK_EN blanks the tens slot when the tens digit is 0.
module bcd_seg_mux #(
    parameter int REFRESH_DIV = 50000,
    parameter int GAP_CYCLES  = 16
) (
    input  logic          CLK,
    input  logic          RST_N,
    bcd_seg_mux_if.slave  dif
);
    localparam int MAX_RG  = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int MAX_LEN = (MAX_RG > 1) ? MAX_RG : 1;
    localparam int CW      = $clog2(MAX_LEN) + 1;
    localparam bit HAS_GAP = (GAP_CYCLES > 0);
    localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(HAS_GAP ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {OFF, GAP0, SHOW_ONES, GAP1, SHOW_TENS} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    snap_ones_q, snap_ones_d;
    logic [3:0]    snap_tens_q, snap_tens_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;
    logic          tick_q, tick_d;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        snap_ones_d = snap_ones_q;
        snap_tens_d = snap_tens_q;
        tick_d      = 1'b0;
        an_d        = 2'b11;
        seg_d       = 7'h7F;

        if (!dif.enable) begin
            state_d = OFF;
        end else begin
            case (state_q)
                OFF:       state_d = HAS_GAP ? GAP0 : SHOW_ONES;
                GAP0:      if (cnt_q == GAP_LAST)  state_d = SHOW_ONES;
                SHOW_ONES: if (cnt_q == SHOW_LAST) state_d = HAS_GAP ? GAP1 : SHOW_TENS;
                GAP1:      if (cnt_q == GAP_LAST)  state_d = SHOW_TENS;
                SHOW_TENS: if (cnt_q == SHOW_LAST) state_d = HAS_GAP ? GAP0 : SHOW_ONES;
                default:   state_d = OFF;
            endcase
        end

        if (state_d != state_q || state_d == OFF) cnt_d = '0;

        // Both digits are latched together on frame entry so the pair is never torn.
        if (state_d == SHOW_ONES && state_q != SHOW_ONES) begin
            snap_ones_d = dif.digit_1;
            snap_tens_d = dif.digit_2;
            tick_d      = 1'b1;
        end

        // Outputs follow the next state so they change on the transition edge.
        case (state_d)
            SHOW_ONES: begin
                an_d  = 2'b10;
                seg_d = decode(snap_ones_d);
            end
            SHOW_TENS: begin
`ifdef LEADING_ZERO_BLANK_EN
                if (snap_tens_d != 4'd0) begin
                    an_d  = 2'b01;
                    seg_d = decode(snap_tens_d);
                end
`else
                an_d  = 2'b01;
                seg_d = decode(snap_tens_d);
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= GAP0;
            cnt_q       <= '0;
            snap_ones_q <= '0;
            snap_tens_q <= '0;
            seg_q       <= 7'h7F;
            an_q        <= 2'b11;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            snap_ones_q <= snap_ones_d;
            snap_tens_q <= snap_tens_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            tick_q      <= tick_d;
        end
    end

    assign dif.seg        = seg_q;
    assign dif.an         = an_q;
    assign dif.frame_tick = tick_q;
endmodule
